// File: rtl/seq_multiplier_nxn.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier_nxn
// Brief   : Sequential WIDTH x WIDTH multiplier, DIGIT bits of b per cycle,
//           unsigned or two's complement, with start/busy/done handshake.
// Rev     : 1.0
// ============================================================================
module seq_multiplier_nxn #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH / DIGIT;
    localparam int PW = WIDTH + DIGIT;
    localparam int AW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic             r_neg;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_neg;
    logic [DIGIT-1:0] w_digit;
    logic [PW-1:0]    w_pp;
    logic [AW-1:0]    w_acc_next;

    // The magnitude of the most negative operand still fits in WIDTH unsigned bits.
    always_comb begin
        w_abs_a    = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        w_abs_b    = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        w_neg      = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        w_digit    = r_mb[WIDTH-1 -: DIGIT];
        w_pp       = PW'(r_ma) * PW'(w_digit);
        w_acc_next = (r_acc << DIGIT) + AW'(w_pp);
    end

    // busy/done are registered from the state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            busy <= (r_state == S_CALC) || (r_state == S_FIX);
            done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_ma    <= w_abs_a;
                        r_mb    <= w_abs_b;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_mb  <= r_mb << DIGIT;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    product <= r_neg ? (~r_acc + AW'(1)) : r_acc;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_nxn.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_multiplier_nxn
// Brief   : Bench for seq_multiplier_nxn in three configurations (8/2, 4/4, 16/4).
// Rev     : 1.0
// ============================================================================
module tb_seq_multiplier_nxn;

    logic        clk;
    logic        rst;
    logic [2:0]  st;
    logic [15:0] a_drv;
    logic [15:0] b_drv;
    logic        sm_drv;

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] prod0;
    logic [7:0]  prod1;
    logic [31:0] prod2;

    int tests;
    int fails;

    seq_multiplier_nxn #(.WIDTH(8), .DIGIT(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .a(a_drv[7:0]), .b(b_drv[7:0]),
        .signed_mode(sm_drv), .busy(busy0), .done(done0), .product(prod0)
    );

    seq_multiplier_nxn #(.WIDTH(4), .DIGIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .a(a_drv[3:0]), .b(b_drv[3:0]),
        .signed_mode(sm_drv), .busy(busy1), .done(done1), .product(prod1)
    );

    seq_multiplier_nxn #(.WIDTH(16), .DIGIT(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .a(a_drv), .b(b_drv),
        .signed_mode(sm_drv), .busy(busy2), .done(done2), .product(prod2)
    );

    always #5 clk = ~clk;

    function automatic int cfg_w(input int k);
        case (k)
            0:       return 8;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_n(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] get_prod(input int k);
        case (k)
            0:       return {16'd0, prod0};
            1:       return {24'd0, prod1};
            default: return prod2;
        endcase
    endfunction

    function automatic logic get_done(input int k);
        case (k)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
    function automatic logic [31:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic sm);
        longint sa, sb, p, m;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [15:0] m;
        int r;
        m = 16'((32'd1 << w) - 1);
        r = $urandom_range(0, 7);
        case (r)
            0:       return 16'd0;
            1:       return m;
            2:       return 16'(32'd1 << (w - 1));
            default: return 16'($urandom) & m;
        endcase
    endfunction

    task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic sm, input logic [31:0] exp, input string nm);
        int   lat;
        int   bcnt;
        logic seen;
        @(negedge clk);
        a_drv = a; b_drv = b; sm_drv = sm; st[k] = 1'b1;
        @(posedge clk);
        #1;
        st[k] = 1'b0;
        a_drv = 16'($urandom); b_drv = 16'($urandom); sm_drv = 1'($urandom);
        lat = 0; bcnt = 0; seen = 1'b0;
        while (!seen && lat < cfg_n(k) + 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (get_busy(k)) bcnt++;
            if (get_done(k)) seen = 1'b1;
        end
        tests++;
        if (lat !== cfg_n(k) + 2) begin
            fails++;
            $display("FAIL %s latency: got %0d edges, expected %0d", nm, lat, cfg_n(k) + 2);
        end
        tests++;
        if (get_prod(k) !== exp) begin
            fails++;
            $display("FAIL %s product: got 0x%08h, expected 0x%08h", nm, get_prod(k), exp);
        end
        tests++;
        if (bcnt !== cfg_n(k) + 1) begin
            fails++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", nm, bcnt, cfg_n(k) + 1);
        end
        @(posedge clk);
        #1;
        tests++;
        if (get_done(k) !== 1'b0) begin
            fails++;
            $display("FAIL %s done pulse width: done=%b after pulse, expected 0", nm, get_done(k));
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (get_busy(k) !== 1'b0 || get_done(k) !== 1'b0 || get_prod(k) !== 32'd0) begin
                fails++;
                $display("FAIL reset cfg%0d: busy=%b done=%b product=0x%08h, expected 0/0/0",
                         k, get_busy(k), get_done(k), get_prod(k));
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_unsigned_basic();
        do_op(0, 16'd13, 16'd11, 1'b0, 32'h008F, "u13x11");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (prod0 !== 16'h008F || done0 !== 1'b0) begin
                fails++;
                $display("FAIL hold cycle %0d: product=0x%04h done=%b, expected 0x008F/0", i, prod0, done0);
            end
        end
    endtask

    task automatic test_unsigned_extremes();
        do_op(0, 16'h00FF, 16'h00FF, 1'b0, 32'hFE01, "uFFxFF");
        do_op(0, 16'h00FD, 16'h0005, 1'b0, 32'h04F1, "uFDx05");
    endtask

    task automatic test_signed();
        do_op(0, 16'h00FD, 16'h0005, 1'b1, 32'hFFF1, "s-3x5");
        do_op(0, 16'h0080, 16'h0080, 1'b1, 32'h4000, "s80x80");
        do_op(0, 16'h0080, 16'h0001, 1'b1, 32'hFF80, "s80x01");
        do_op(0, 16'h0000, 16'h0080, 1'b1, 32'h0000, "s00x80");
    endtask

    task automatic test_ignore_start();
        int   lat;
        logic seen;
        int   extra;
        @(negedge clk);
        a_drv = 16'd7; b_drv = 16'd9; sm_drv = 1'b0; st[0] = 1'b1;
        @(posedge clk);
        #1;
        a_drv = 16'h00FF; b_drv = 16'h00FF; sm_drv = 1'b1;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 4) st[0] = 1'b0;
            if (done0) seen = 1'b1;
        end
        st[0] = 1'b0;
        tests++;
        if (lat !== 6 || prod0 !== 16'd63) begin
            fails++;
            $display("FAIL ignore_start: latency=%0d product=0x%04h, expected 6/0x003F", lat, prod0);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL ignore_start idle: %0d busy/done cycles, expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq[$];
        logic [31:0] exp;
        logic        exp_d;
        int          extra;
        @(negedge clk);
        for (int idx = 0; idx <= 24; idx++) begin
            st[0]  = (idx < 24);
            a_drv  = 16'($urandom);
            b_drv  = 16'($urandom);
            sm_drv = 1'($urandom);
            if ((idx % 6) == 0 && idx < 24) expq.push_back(model(8, a_drv, b_drv, sm_drv));
            @(posedge clk);
            #1;
            if (idx >= 1) begin
                exp_d = ((idx % 6) == 0);
                tests++;
                if (done0 !== exp_d) begin
                    fails++;
                    $display("FAIL b2b done at edge %0d: got %b, expected %b", idx, done0, exp_d);
                end
                if (exp_d && expq.size() > 0) begin
                    exp = expq.pop_front();
                    tests++;
                    if ({16'd0, prod0} !== exp) begin
                        fails++;
                        $display("FAIL b2b product at edge %0d: got 0x%04h, expected 0x%04h", idx, prod0, exp[15:0]);
                    end
                end
            end
        end
        st[0] = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL b2b tail: %0d busy/done cycles after start dropped, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        @(negedge clk);
        a_drv = 16'd13; b_drv = 16'd11; sm_drv = 1'b0; st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tests++;
        if (busy0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid busy: got %b, expected 0", busy0);
        end
        tests++;
        if (done0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid done: got %b, expected 0", done0);
        end
        tests++;
        if (prod0 !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid product: got 0x%04h, expected 0x0000", prod0);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL reset_mid aftermath: %0d busy/done cycles, expected 0", extra);
        end
        do_op(0, 16'd13, 16'd11, 1'b0, 32'h008F, "after_reset");
    endtask

    task automatic test_param_sweep();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        do_op(1, 16'h000F, 16'h000F, 1'b0, 32'h00E1, "w4_15x15");
        do_op(2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_max");
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = pick(cfg_w(k));
                rb = pick(cfg_w(k));
                rs = 1'($urandom);
                do_op(k, ra, rb, rs, model(cfg_w(k), ra, rb, rs), "rand");
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; st = 3'b000;
        a_drv = 16'd0; b_drv = 16'd0; sm_drv = 1'b0;
        tests = 0; fails = 0;
        test_reset();
        test_unsigned_basic();
        test_unsigned_extremes();
        test_signed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
